// File: rtl/key_led_ctrl.sv
// -----------------------------------------------------------------------------
// key_led_ctrl
//   Multi-channel push-button front end. Each of CH active-low raw keys is
//   synchronised (2 FF), debounced (DEB_CNT consecutive stable cycles) and
//   drives one LED, either following the key (mode=0) or toggling on each
//   accepted press (mode=1). A one-cycle pulse is exported per accepted press.
//
// Optional feature macro: TOGGLE_BLINK_EN
//   When defined, a lit toggle-mode LED blinks with a half-period of
//   BLINK_HALF cycles instead of being steadily on.
//
// Ports
//   sys_clk    in   1   system clock, rising edge
//   sys_rst    in   1   synchronous, active-high reset
//   key        in   CH  raw asynchronous keys, active low (1 = released)
//   mode       in   CH  per-channel mode: 0 = follow, 1 = toggle
//   led        out  CH  LED drive, active high, registered
//   key_press  out  CH  one-cycle pulse per accepted press, registered
// -----------------------------------------------------------------------------
module key_led_ctrl #(
    parameter int CH         = 4,
    parameter int DEB_CNT    = 1000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [CH-1:0] key,
    input  logic [CH-1:0] mode,
    output logic [CH-1:0] led,
    output logic [CH-1:0] key_press
);

    localparam int                CNT_W   = $clog2(DEB_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CNT - 1);

    logic [CH-1:0]            r_s1;
    logic [CH-1:0]            r_s2;
    logic [CH-1:0]            r_stable;
    logic [CH-1:0]            r_stable_d;
    logic [CH-1:0]            r_tog;
    logic [CH-1:0][CNT_W-1:0] r_cnt;

    logic [CH-1:0]            w_fall;
    logic [CH-1:0]            w_tog_next;
    logic [CH-1:0]            w_tog_show;
    logic [CH-1:0]            w_led_next;

    // A press is the cycle after stable went 1->0; comparing against the
    // delayed copy places the pulse exactly one cycle behind the stable edge.
    assign w_fall     = r_stable_d & ~r_stable;
    assign w_tog_next = r_tog ^ w_fall;

`ifdef TOGGLE_BLINK_EN
    localparam int                BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLK_W-1:0]  BLK_MAX = BLK_W'(BLINK_HALF - 1);

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase;

    // Shared free-running blink timebase for all toggle-mode channels.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BLK_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    assign w_tog_show = w_tog_next & {CH{r_phase}};
`else
    assign w_tog_show = w_tog_next;
`endif

    // Mode is applied combinationally so a mode switch shows on the next edge.
    always_comb begin
        w_led_next = '0;
        for (int i = 0; i < CH; i++) begin
            w_led_next[i] = mode[i] ? w_tog_show[i] : ~r_stable[i];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1       <= '1;
            r_s2       <= '1;
            r_stable   <= '1;
            r_stable_d <= '1;
            r_tog      <= '0;
            r_cnt      <= '0;
            led        <= '0;
            key_press  <= '0;
        end else begin
            // stage: synchroniser
            r_s1 <= key;
            r_s2 <= r_s1;

            // stage: debounce; any return to the stable level restarts the run
            for (int i = 0; i < CH; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

            // stage: edge detect, toggle state and outputs
            r_stable_d <= r_stable;
            key_press  <= w_fall;
            r_tog      <= w_tog_next;
            led        <= w_led_next;
        end
    end

endmodule
